jtdsp16_do_ctrl: RTL and testbench

- Sequencer for DSP16 "do K {N instr}" and "redo K" loops.
- Decodes the loop instruction fields and tracks the position within the loop body and the remaining iteration count.
- Drives the loop-cache control strobes (do_start, do_redo, do_save, do_out, do_short, do_pc) of the ROM address arithmetic unit.
- Sits between the instruction decoder and the ROM AAU, and masks interrupts while a loop runs.

---
 rtl/jtdsp16_do_ctrl.sv | 121 ++++++++++++
 tb/tb_jtdsp16_do_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_do_ctrl.sv
// Loop sequencer for DSP16 "do K {N instr}" / "redo K": drives the ROM AAU
// loop-cache strobes, tracks body position and remaining iterations.
module jtdsp16_do_ctrl #(
   parameter int CACHE_DEPTH = 15,
   parameter int KW          = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        do_en,
   input  logic        redo_en,
   input  logic [10:0] i_field,
   output logic        do_start,
   output logic        do_redo,
   output logic        do_save,
   output logic        do_short,
   output logic        do_out,
   output logic [3:0]  do_pc,
   output logic [10:0] do_data,
   output logic [3:0]  do_len,
   output logic        busy,
   output logic        irq_mask,
   output logic        nest_err
);

   typedef enum logic { IDLE = 1'b0, LOOP = 1'b1 } state_t;

   localparam logic [3:0]    MAX_LEN  = 4'(CACHE_DEPTH);
   localparam logic [KW-1:0] ITER_ONE = {{(KW-1){1'b0}}, 1'b1};

   state_t        state, nxt_state;
   logic          has_body;
   logic [KW-1:0] iter;
   logic [3:0]    fld_n;
   logic [KW-1:0] fld_k;
   logic          start_do, start_redo;
   logic          last_pc;

   function automatic logic [3:0] clamp_len(input logic [3:0] n);
      if (n > MAX_LEN) return MAX_LEN;
      return n;
   endfunction

   assign fld_n    = i_field[10:7];
   assign fld_k    = i_field[KW-1:0];
   assign last_pc  = (do_pc == (do_len - 4'd1));
   assign busy     = (state == LOOP);
   assign irq_mask = busy;
   assign do_start = start_do | start_redo;
   assign do_save  = start_do;
   assign do_redo  = start_redo;
   // A new "do" reports its own (clamped) length; a redo reuses the stored one
   assign do_short = busy       ? (do_len == 4'd1) :
                     start_do   ? (clamp_len(fld_n) == 4'd1) :
                     start_redo ? (do_len == 4'd1) : 1'b0;

   always_comb begin
      nxt_state  = state;
      start_do   = 1'b0;
      start_redo = 1'b0;
      do_out     = 1'b0;
      case (state)
         IDLE: begin
            if (do_en) begin
               if (fld_n != 4'd0 && fld_k != '0) begin
                  start_do  = 1'b1;
                  nxt_state = LOOP;
               end
            end else if (redo_en && has_body && fld_k != '0) begin
               start_redo = 1'b1;
               nxt_state  = LOOP;
            end
         end
         LOOP: begin
            if (last_pc && iter == ITER_ONE) begin
               do_out    = 1'b1;
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else if (cen) state <= nxt_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         has_body <= 1'b0;
         iter     <= '0;
         do_pc    <= 4'd0;
         do_data  <= 11'd0;
         do_len   <= 4'd0;
         nest_err <= 1'b0;
      end else if (cen) begin
         if (busy && (do_en || redo_en)) nest_err <= 1'b1;
         if (do_start) begin
            iter  <= fld_k;
            do_pc <= 4'd0;
            if (start_do) begin
               do_len   <= clamp_len(fld_n);
               has_body <= 1'b1;
               do_data  <= i_field;
            end else begin
               do_data  <= {do_len, i_field[6:0]};
            end
         end else if (busy) begin
            if (last_pc) begin
               do_pc <= 4'd0;
               // On the final pass iter stays at 1; the FSM leaves LOOP instead
               if (iter != ITER_ONE) iter <= iter - ITER_ONE;
            end else begin
               do_pc <= do_pc + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_jtdsp16_do_ctrl.sv
// Bench for jtdsp16_do_ctrl: a queue of expected (pc, out) beats per loop
// plus directed scenarios and a randomized run.
module tb_jtdsp16_do_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b0;
   logic        do_en = 1'b0;
   logic        redo_en = 1'b0;
   logic [10:0] i_field = 11'd0;
   logic        do_start, do_redo, do_save, do_short, do_out;
   logic [3:0]  do_pc, do_len;
   logic [10:0] do_data;
   logic        busy, irq_mask, nest_err;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   jtdsp16_do_ctrl #(.CACHE_DEPTH(15), .KW(7)) dut (
      .clk(clk), .rst(rst), .cen(cen), .do_en(do_en), .redo_en(redo_en),
      .i_field(i_field), .do_start(do_start), .do_redo(do_redo),
      .do_save(do_save), .do_short(do_short), .do_out(do_out),
      .do_pc(do_pc), .do_data(do_data), .do_len(do_len), .busy(busy),
      .irq_mask(irq_mask), .nest_err(nest_err)
   );

   always #5 clk = ~clk;

   // Reference model: each accepted loop expands into its full beat list
   typedef struct { logic [3:0] pc; logic out; } beat_t;
   beat_t       q[$];
   logic        m_has_body = 1'b0;
   logic [3:0]  m_len = 4'd0;
   logic [10:0] m_data = 11'd0;
   logic        m_nest = 1'b0;

   logic        e_start, e_save, e_redo, e_out, e_busy, e_short;
   logic [3:0]  e_pc;

   function automatic logic [10:0] fld(input int n, input int k);
      logic [3:0] nn;
      logic [6:0] kk;
      nn = 4'(n);
      kk = 7'(k);
      return {nn, kk};
   endfunction

   function automatic logic [25:0] pack_act();
      return {do_start, do_save, do_redo, do_out, busy, irq_mask, nest_err,
              do_pc, do_len, do_data};
   endfunction

   function automatic logic [25:0] pack_exp();
      return {e_start, e_save, e_redo, e_out, e_busy, e_busy, m_nest,
              e_pc, m_len, m_data};
   endfunction

   task automatic model_reset();
      q.delete();
      m_has_body = 1'b0;
      m_len      = 4'd0;
      m_data     = 11'd0;
      m_nest     = 1'b0;
   endtask

   // Apply inputs just after a posedge, then compute expectations at negedge
   task automatic drive(input logic d, input logic r, input logic [10:0] f, input logic c);
      int n, k;
      do_en = d; redo_en = r; i_field = f; cen = c;
      @(negedge clk);
      n = int'(f[10:7]);
      k = int'(f[6:0]);
      e_busy  = (q.size() != 0);
      e_save  = !e_busy && d && n != 0 && k != 0;
      e_redo  = !e_busy && !d && r && m_has_body && k != 0;
      e_start = e_save || e_redo;
      e_pc    = e_busy ? q[0].pc : 4'd0;
      e_out   = e_busy ? q[0].out : 1'b0;
      e_short = e_busy && (m_len == 4'd1);
   endtask

   task automatic commit();
      int len, k;
      @(posedge clk);
      if (cen) begin
         if (e_busy) begin
            if (do_en || redo_en) m_nest = 1'b1;
            void'(q.pop_front());
         end else if (e_start) begin
            k = int'(i_field[6:0]);
            if (e_save) begin
               len = (int'(i_field[10:7]) > 15) ? 15 : int'(i_field[10:7]);
               m_len      = 4'(len);
               m_has_body = 1'b1;
               m_data     = i_field;
            end else begin
               len    = int'(m_len);
               m_data = {m_len, i_field[6:0]};
            end
            for (int it = k; it >= 1; it--)
               for (int p = 0; p < len; p++)
                  q.push_back('{pc: 4'(p), out: (it == 1 && p == len - 1)});
         end
      end
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vec_cnt++;
      if (pack_act() !== 26'd0 || do_short !== 1'b0) begin
         miss_cnt++;
         $display("FAIL reset_state got %h want 0", pack_act());
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_do_basic();
      for (int i = 0; i < 9; i++) begin
         drive(i == 0, 1'b0, (i == 0) ? fld(3, 2) : 11'd0, 1'b1);
         vec_cnt++;
         if (pack_act() !== pack_exp()) begin
            miss_cnt++;
            $display("FAIL do_basic cyc%0d got %h want %h", i, pack_act(), pack_exp());
         end
         commit();
      end
   endtask

   task automatic test_redo();
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, i == 0, (i == 0) ? fld(9, 3) : 11'd0, 1'b1);
         vec_cnt++;
         if (pack_act() !== pack_exp()) begin
            miss_cnt++;
            $display("FAIL redo cyc%0d got %h want %h", i, pack_act(), pack_exp());
         end
         commit();
      end
   endtask

   task automatic test_short();
      for (int i = 0; i < 8; i++) begin
         drive(i == 0 || i == 6, 1'b0, (i == 0) ? fld(1, 4) : fld(2, 0), 1'b1);
         vec_cnt++;
         if (pack_act() !== pack_exp() || (e_busy && do_short !== e_short)) begin
            miss_cnt++;
            $display("FAIL short cyc%0d got %h/%b want %h/%b", i, pack_act(), do_short,
                     pack_exp(), e_short);
         end
         commit();
      end
   endtask

   task automatic test_nest_after_reset();
      pulse_reset();
      for (int i = 0; i < 10; i++) begin
         drive(i == 1 || i == 3, i == 0, (i == 1) ? fld(3, 2) : (i == 0) ? fld(0, 3) : fld(2, 5), 1'b1);
         vec_cnt++;
         if (pack_act() !== pack_exp()) begin
            miss_cnt++;
            $display("FAIL nest cyc%0d got %h want %h", i, pack_act(), pack_exp());
         end
         commit();
      end
   endtask

   task automatic test_cen();
      for (int i = 0; i < 11; i++) begin
         drive(i == 0, 1'b0, (i == 0) ? fld(2, 2) : 11'd0, (i % 2) == 0);
         vec_cnt++;
         if (pack_act() !== pack_exp()) begin
            miss_cnt++;
            $display("FAIL cen cyc%0d got %h want %h", i, pack_act(), pack_exp());
         end
         commit();
      end
   endtask

   task automatic test_reset_midloop();
      for (int i = 0; i < 3; i++) begin
         drive(i == 0, 1'b0, fld(4, 5), 1'b1);
         commit();
      end
      vec_cnt++;
      if (do_pc !== 4'd2) begin
         miss_cnt++;
         $display("FAIL midloop_pc got %0d want 2", do_pc);
      end
      drive(1'b0, 1'b0, 11'd0, 1'b1);
      rst = 1'b1;
      #1;
      model_reset();
      vec_cnt++;
      if (pack_act() !== 26'd0) begin
         miss_cnt++;
         $display("FAIL async_reset got %h want 0", pack_act());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, i == 0, fld(0, 1), 1'b1);
         vec_cnt++;
         if (pack_act() !== pack_exp()) begin
            miss_cnt++;
            $display("FAIL redo_after_rst cyc%0d got %h want %h", i, pack_act(), pack_exp());
         end
         commit();
      end
   endtask

   task automatic test_random();
      logic d, r, c;
      logic [10:0] f;
      for (int i = 0; i < 600; i++) begin
         d = ($urandom_range(0, 7) == 0);
         r = ($urandom_range(0, 7) == 0);
         c = ($urandom_range(0, 3) != 0);
         f = 11'($urandom);
         if ($urandom_range(0, 3) == 0) f[10:7] = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 3) != 0) f[6:0] = 7'($urandom_range(0, 4));
         drive(d, r, f, c);
         vec_cnt++;
         if (pack_act() !== pack_exp() || (e_busy && do_short !== e_short)) begin
            miss_cnt++;
            $display("FAIL random cyc%0d got %h/%b want %h/%b", i, pack_act(), do_short,
                     pack_exp(), e_short);
         end
         commit();
         if (i == 300) pulse_reset();
      end
   endtask

   initial begin
      test_reset();
      test_do_basic();
      test_redo();
      test_short();
      test_nest_after_reset();
      test_cen();
      test_reset_midloop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
